// File: rtl/mpi_eth_pkg.sv
// Shared definitions for the MPI-over-Ethernet send/done block.
package mpi_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HDR       = 2'd1,
    ST_PAYLOAD   = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam logic [15:0] ETHERTYPE = 16'h88B5;
  localparam logic [7:0]  OP_SEND   = 8'h01;
  localparam logic [7:0]  OP_DONE   = 8'h02;

  // Header beats sent, and the exact length of a DONE reply.
  localparam int unsigned HDR_BEATS    = 4;
  localparam logic [1:0]  HDR_LAST_IDX = 2'(HDR_BEATS - 1);

endpackage

// File: rtl/mpi_eth_done_matcher.sv
// Watches the receive stream and pulses match_o on the last beat of a
// 4-beat DONE packet whose fields agree with the stored send command.
// A packet only qualifies if its first beat arrives while arm_i is high,
// so a packet already in flight when arming happens is ignored.
module mpi_done_matcher
  import mpi_eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        arm_i,
  input  logic        beat_i,
  input  logic [63:0] data_i,
  input  logic        last_i,
  input  logic [63:0] exp_b0_i,
  input  logic [63:0] exp_b1_i,
  input  logic [63:0] exp_b2_i,
  input  logic [23:0] exp_b3_hi_i,
  output logic        match_o
);

  // Beat index within the current packet; saturates one past the last
  // valid index so over-long packets stay marked as mismatching.
  logic [2:0] cnt_q, cnt_d;
  logic       mis_q, mis_d;
  logic       beat_ok;

  // Judge the current beat against the expected reply.
  always_comb begin
    beat_ok = 1'b0;
    case (cnt_q)
      3'd0:    beat_ok = arm_i && (data_i == exp_b0_i);
      3'd1:    beat_ok = (data_i == exp_b1_i);
      3'd2:    beat_ok = (data_i == exp_b2_i);
      3'd3:    beat_ok = (data_i[63:40] == exp_b3_hi_i);
      default: beat_ok = 1'b0;
    endcase
    // last must land exactly on the final beat, nowhere else
    if (last_i != (cnt_q == 3'(HDR_BEATS - 1))) beat_ok = 1'b0;
  end

  // Counter and mismatch tracking; both clear on every packet end.
  always_comb begin
    cnt_d = cnt_q;
    mis_d = mis_q;
    if (beat_i) begin
      if (last_i) begin
        cnt_d = 3'd0;
        mis_d = 1'b0;
      end else begin
        if (cnt_q != 3'(HDR_BEATS)) cnt_d = cnt_q + 3'd1;
        if (!beat_ok) mis_d = 1'b1;
      end
    end
  end

  assign match_o = beat_i && last_i && arm_i && !mis_q && beat_ok;

  // Receive tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 3'd0;
      mis_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

endmodule

// File: rtl/mpi_eth_interface.sv
// MPI send engine over raw Ethernet: takes a send command, emits a 4-beat
// header, passes the payload through, then waits for the matching DONE
// reply on the receive stream before accepting the next command.
//
// Handshakes: a beat moves on a rising clk edge when valid and ready are
// both high; a source holds its beat stable while ready is low.
module mpi_eth_interface #(
  parameter logic [15:0] ETHERTYPE = mpi_eth_pkg::ETHERTYPE,
  parameter logic [7:0]  OP_SEND   = mpi_eth_pkg::OP_SEND,
  parameter logic [7:0]  OP_DONE   = mpi_eth_pkg::OP_DONE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_dst_rank,
  input  logic [7:0]  cmd_src_rank,
  input  logic [31:0] cmd_size,
  input  logic [47:0] cmd_mac_dst,
  input  logic [47:0] cmd_mac_src,
  input  logic [31:0] cmd_ip_dst,
  input  logic [31:0] cmd_ip_src,
  input  logic [63:0] pay_data,
  input  logic [7:0]  pay_keep,
  input  logic        pay_last,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [63:0] stream_out_data,
  output logic [7:0]  stream_out_keep,
  output logic        stream_out_last,
  output logic        stream_out_valid,
  input  logic        stream_out_ready,
  input  logic [63:0] stream_in_data,
  input  logic [7:0]  stream_in_keep,
  input  logic        stream_in_last,
  input  logic        stream_in_valid,
  output logic        stream_in_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);
  import mpi_eth_pkg::*;

  state_e      state_q, state_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic        cmd_load;
  logic [15:0] dst_rank_q;
  logic [7:0]  src_rank_q;
  logic [31:0] size_q;
  logic [47:0] mac_dst_q, mac_src_q;
  logic [31:0] ip_dst_q, ip_src_q;
  logic [63:0] hdr_beat;
  logic        match;
  logic        unused_in_keep;

  // Receive keep carries no information for matching.
  assign unused_in_keep = ^stream_in_keep;

  // Header beat selected by the current index; byte 0 is bits 63:56.
  always_comb begin
    case (hdr_idx_q)
      2'd0:    hdr_beat = {mac_dst_q, mac_src_q[47:32]};
      2'd1:    hdr_beat = {mac_src_q[31:0], ETHERTYPE, OP_SEND, 8'h00};
      2'd2:    hdr_beat = {ip_dst_q, ip_src_q};
      default: hdr_beat = {dst_rank_q, src_rank_q, 8'h00, size_q};
    endcase
  end

  // Next-state and output decode; outputs are also gated by rst so they
  // drop the instant reset is raised.
  always_comb begin
    state_d          = state_q;
    hdr_idx_d        = hdr_idx_q;
    cmd_load         = 1'b0;
    cmd_ready        = 1'b0;
    pay_ready        = 1'b0;
    stream_out_data  = 64'd0;
    stream_out_keep  = 8'h00;
    stream_out_last  = 1'b0;
    stream_out_valid = 1'b0;
    stream_in_ready  = !rst;
    busy             = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          cmd_load  = 1'b1;
          hdr_idx_d = 2'd0;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        stream_out_data  = hdr_beat;
        stream_out_keep  = 8'hFF;
        stream_out_valid = !rst;
        if (stream_out_ready) begin
          if (hdr_idx_q == HDR_LAST_IDX) begin
            hdr_idx_d = 2'd0;
            state_d   = ST_PAYLOAD;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        stream_out_data  = pay_data;
        stream_out_keep  = pay_keep;
        stream_out_last  = pay_last;
        stream_out_valid = pay_valid && !rst;
        pay_ready        = stream_out_ready && !rst;
        if (pay_valid && stream_out_ready && pay_last) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (match) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done      = match;
  assign dbg_state = state_q;

  // State and header index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
    end
  end

  // Stored command, captured when a command is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_rank_q <= 16'd0;
      src_rank_q <= 8'd0;
      size_q     <= 32'd0;
      mac_dst_q  <= 48'd0;
      mac_src_q  <= 48'd0;
      ip_dst_q   <= 32'd0;
      ip_src_q   <= 32'd0;
    end else if (cmd_load) begin
      dst_rank_q <= cmd_dst_rank;
      src_rank_q <= cmd_src_rank;
      size_q     <= cmd_size;
      mac_dst_q  <= cmd_mac_dst;
      mac_src_q  <= cmd_mac_src;
      ip_dst_q   <= cmd_ip_dst;
      ip_src_q   <= cmd_ip_src;
    end
  end

  // The DONE reply mirrors the header with source and destination swapped.
  mpi_done_matcher u_matcher (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (state_q == ST_WAIT_DONE),
    .beat_i      (stream_in_valid && stream_in_ready),
    .data_i      (stream_in_data),
    .last_i      (stream_in_last),
    .exp_b0_i    ({mac_src_q, mac_dst_q[47:32]}),
    .exp_b1_i    ({mac_dst_q[31:0], ETHERTYPE, OP_DONE, 8'h00}),
    .exp_b2_i    ({ip_src_q, ip_dst_q}),
    .exp_b3_hi_i ({8'h00, src_rank_q, dst_rank_q[7:0]}),
    .match_o     (match)
  );

endmodule

// File: tb/tb_mpi_eth_interface.sv
// Bench for mpi_eth_interface: transmit beats are checked against a
// scoreboard queue filled as commands and payload are driven.
module tb_mpi_eth_interface;

  localparam logic [15:0] ETH = 16'h88B5;

  typedef struct packed {
    logic [15:0] dst;
    logic [7:0]  src;
    logic [31:0] size;
    logic [47:0] macd;
    logic [47:0] macs;
    logic [31:0] ipd;
    logic [31:0] ips;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_dst_rank = '0;
  logic [7:0]  cmd_src_rank = '0;
  logic [31:0] cmd_size = '0;
  logic [47:0] cmd_mac_dst = '0, cmd_mac_src = '0;
  logic [31:0] cmd_ip_dst = '0, cmd_ip_src = '0;
  logic [63:0] pay_data = '0;
  logic [7:0]  pay_keep = '0;
  logic        pay_last = 1'b0, pay_valid = 1'b0, pay_ready;
  logic [63:0] stream_out_data;
  logic [7:0]  stream_out_keep;
  logic        stream_out_last, stream_out_valid;
  logic        stream_out_ready = 1'b1;
  logic [63:0] stream_in_data = '0;
  logic [7:0]  stream_in_keep = '0;
  logic        stream_in_last = 1'b0, stream_in_valid = 1'b0, stream_in_ready;
  logic        busy, done;
  logic [1:0]  dbg_state;

  int          n_run = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  bit          bp_en = 1'b0;
  logic [72:0] exp_q[$];
  logic [72:0] exp_beat;

  mpi_eth_interface dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_rank(cmd_dst_rank), .cmd_src_rank(cmd_src_rank), .cmd_size(cmd_size),
    .cmd_mac_dst(cmd_mac_dst), .cmd_mac_src(cmd_mac_src),
    .cmd_ip_dst(cmd_ip_dst), .cmd_ip_src(cmd_ip_src),
    .pay_data(pay_data), .pay_keep(pay_keep), .pay_last(pay_last),
    .pay_valid(pay_valid), .pay_ready(pay_ready),
    .stream_out_data(stream_out_data), .stream_out_keep(stream_out_keep),
    .stream_out_last(stream_out_last), .stream_out_valid(stream_out_valid),
    .stream_out_ready(stream_out_ready),
    .stream_in_data(stream_in_data), .stream_in_keep(stream_in_keep),
    .stream_in_last(stream_in_last), .stream_in_valid(stream_in_valid),
    .stream_in_ready(stream_in_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Transmit-side backpressure generator.
  always @(posedge clk) begin
    #1;
    stream_out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && stream_out_valid && stream_out_ready) begin
      n_run++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_beat: unexpected beat data=%h keep=%h last=%b, required none",
                 stream_out_data, stream_out_keep, stream_out_last);
      end else begin
        exp_beat = exp_q.pop_front();
        if ({stream_out_last, stream_out_keep, stream_out_data} !== exp_beat) begin
          n_fail++;
          $display("FAIL out_beat: got last=%b keep=%h data=%h, required last=%b keep=%h data=%h",
                   stream_out_last, stream_out_keep, stream_out_data,
                   exp_beat[72], exp_beat[71:64], exp_beat[63:0]);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] hdr_word(input cmd_t c, input int i);
    case (i)
      0:       return {c.macd, c.macs[47:32]};
      1:       return {c.macs[31:0], ETH, 8'h01, 8'h00};
      2:       return {c.ipd, c.ips};
      default: return {c.dst, c.src, 8'h00, c.size};
    endcase
  endfunction

  function automatic logic [63:0] reply_word(input cmd_t c, input int i,
                                             input logic [7:0] opc,
                                             input logic [39:0] low);
    case (i)
      0:       return {c.macs, c.macd[47:32]};
      1:       return {c.macd[31:0], ETH, opc, 8'h00};
      2:       return {c.ips, c.ipd};
      default: return {8'h00, c.src, c.dst[7:0], low};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input cmd_t c);
    @(posedge clk); #1;
    cmd_dst_rank = c.dst;  cmd_src_rank = c.src;  cmd_size = c.size;
    cmd_mac_dst  = c.macd; cmd_mac_src  = c.macs;
    cmd_ip_dst   = c.ipd;  cmd_ip_src   = c.ips;
    cmd_valid    = 1'b1;
    @(negedge clk);
    n_run++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_idle: got %b, required 1", cmd_ready);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'hFF, hdr_word(c, i)});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_payload(input int n, input logic [63:0] base,
                              input logic [63:0] step, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int cyc;
      pay_data  = base + step * 64'(i);
      pay_keep  = 8'hFF;
      pay_last  = with_last && (i == n - 1);
      pay_valid = 1'b1;
      exp_q.push_back({pay_last, 8'hFF, pay_data});
      cyc = 0;
      @(negedge clk);
      while (!pay_ready && cyc < 100) begin
        cyc++;
        @(negedge clk);
      end
      if (!pay_ready) begin
        n_run++;
        n_fail++;
        $display("FAIL pay_ready_timeout: got 0 after %0d cycles, required 1", cyc);
      end
      @(posedge clk); #1;
    end
    pay_valid = 1'b0;
    pay_last  = 1'b0;
  endtask

  task automatic send_rx(input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3,
                         input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      case (i)
        0:       stream_in_data = b0;
        1:       stream_in_data = b1;
        2:       stream_in_data = b2;
        default: stream_in_data = b3;
      endcase
      stream_in_keep  = 8'hFF;
      stream_in_last  = (i == nbeats - 1);
      stream_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    stream_in_valid = 1'b0;
    stream_in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still expected, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  cmd_t c1, c2, c3;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_run++;
    if ({cmd_ready, stream_in_ready, stream_out_valid, pay_ready, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cr=%b sir=%b sov=%b pr=%b busy=%b done=%b, required all 0",
               cmd_ready, stream_in_ready, stream_out_valid, pay_ready, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if ({cmd_ready, stream_in_ready, stream_out_valid, pay_ready, busy, dbg_state} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL post_reset: got cr=%b sir=%b sov=%b pr=%b busy=%b st=%0d, required 1 1 0 0 0 0",
               cmd_ready, stream_in_ready, stream_out_valid, pay_ready, busy, dbg_state);
    end
  endtask

  task automatic test_idle_rx();
    int d0 = done_cnt;
    send_rx(reply_word(c1, 0, 8'h02, 40'h0), reply_word(c1, 1, 8'h02, 40'h0),
            reply_word(c1, 2, 8'h02, 40'h0), reply_word(c1, 3, 8'h02, 40'h0), 4);
    n_run++;
    if (done_cnt !== d0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_rx: got done_pulses=%0d state=%0d, required 0 and 0", done_cnt - d0, dbg_state);
    end
  endtask

  task automatic test_basic_send();
    issue_cmd(c1);
    send_payload(11, 64'd13, 64'd0, 1'b1);
    wait_drain();
    n_run++;
    if (busy !== 1'b1 || dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL basic_wait_done: got busy=%b state=%0d, required 1 and 3", busy, dbg_state);
    end
  endtask

  task automatic test_done_match();
    int d0 = done_cnt;
    send_rx(64'h0cc47a88c047fa16, 64'h3e55ca0288b50200, 64'h0, 64'h0000010000000000, 4);
    @(negedge clk);
    n_run++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL done_pulse: got %0d pulses, required 1", done_cnt - d0);
    end
    n_run++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_idle: got busy=%b state=%0d done=%b, required 0 0 0", busy, dbg_state, done);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    bp_en = 1'b1;
    issue_cmd(c2);
    send_payload(11, 64'h1000, 64'd1, 1'b1);
    wait_drain();
    bp_en = 1'b0;
    n_run++;
    if (dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_state: got %0d, required 3", dbg_state);
    end
    d0 = done_cnt;
    send_rx(reply_word(c2, 0, 8'h02, 40'h0), reply_word(c2, 1, 8'h02, 40'h0),
            reply_word(c2, 2, 8'h02, 40'h0), reply_word(c2, 3, 8'h02, 40'h0), 4);
    n_run++;
    if (done_cnt - d0 !== 1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_done: got pulses=%0d state=%0d, required 1 and 0", done_cnt - d0, dbg_state);
    end
  endtask

  task automatic test_wrong_done();
    int d0;
    issue_cmd(c1);
    send_payload(3, 64'h77, 64'd3, 1'b1);
    wait_drain();
    d0 = done_cnt;
    // src_rank field 2
    send_rx(reply_word(c1, 0, 8'h02, 40'h0), reply_word(c1, 1, 8'h02, 40'h0),
            reply_word(c1, 2, 8'h02, 40'h0), 64'h0002010000000000, 4);
    n_run++;
    if (done_cnt !== d0 || dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL wrong_src: got pulses=%0d state=%0d, required 0 and 3", done_cnt - d0, dbg_state);
    end
    // opcode SEND instead of DONE
    send_rx(reply_word(c1, 0, 8'h01, 40'h0), reply_word(c1, 1, 8'h01, 40'h0),
            reply_word(c1, 2, 8'h01, 40'h0), reply_word(c1, 3, 8'h01, 40'h0), 4);
    n_run++;
    if (done_cnt !== d0 || dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL wrong_op: got pulses=%0d state=%0d, required 0 and 3", done_cnt - d0, dbg_state);
    end
    // correct content but 5 beats long
    send_rx(reply_word(c1, 0, 8'h02, 40'h0), reply_word(c1, 1, 8'h02, 40'h0),
            reply_word(c1, 2, 8'h02, 40'h0), reply_word(c1, 3, 8'h02, 40'h0), 5);
    n_run++;
    if (done_cnt !== d0 || dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL long_pkt: got pulses=%0d state=%0d, required 0 and 3", done_cnt - d0, dbg_state);
    end
    // 3-beat packet ending on the third beat
    send_rx(reply_word(c1, 0, 8'h02, 40'h0), reply_word(c1, 1, 8'h02, 40'h0),
            reply_word(c1, 2, 8'h02, 40'h0), 64'h0, 3);
    n_run++;
    if (done_cnt !== d0 || dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL short_pkt: got pulses=%0d state=%0d, required 0 and 3", done_cnt - d0, dbg_state);
    end
    // correct reply with nonzero ignored low bits
    send_rx(reply_word(c1, 0, 8'h02, 40'h0), reply_word(c1, 1, 8'h02, 40'h0),
            reply_word(c1, 2, 8'h02, 40'h0), reply_word(c1, 3, 8'h02, 40'hDEADBEEF12), 4);
    n_run++;
    if (done_cnt - d0 !== 1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL good_after_bad: got pulses=%0d state=%0d, required 1 and 0", done_cnt - d0, dbg_state);
    end
  endtask

  task automatic test_cmd_while_busy();
    int d0;
    int cyc = 0;
    issue_cmd(c2);
    @(negedge clk);
    while (dbg_state !== 2'd2 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_dst_rank = c3.dst;  cmd_src_rank = c3.src;  cmd_size = c3.size;
    cmd_mac_dst  = c3.macd; cmd_mac_src  = c3.macs;
    cmd_ip_dst   = c3.ipd;  cmd_ip_src   = c3.ips;
    cmd_valid    = 1'b1;
    @(negedge clk);
    n_run++;
    if (cmd_ready !== 1'b0 || dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL busy_cmd_ready: got cr=%b state=%0d, required 0 and 2", cmd_ready, dbg_state);
    end
    @(posedge clk); #1;
    send_payload(3, 64'hABC0, 64'd5, 1'b1);
    cmd_valid = 1'b0;
    wait_drain();
    d0 = done_cnt;
    send_rx(reply_word(c3, 0, 8'h02, 40'h0), reply_word(c3, 1, 8'h02, 40'h0),
            reply_word(c3, 2, 8'h02, 40'h0), reply_word(c3, 3, 8'h02, 40'h0), 4);
    n_run++;
    if (done_cnt !== d0 || dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL busy_fields_kept: got pulses=%0d state=%0d, required 0 and 3", done_cnt - d0, dbg_state);
    end
    send_rx(reply_word(c2, 0, 8'h02, 40'h0), reply_word(c2, 1, 8'h02, 40'h0),
            reply_word(c2, 2, 8'h02, 40'h0), reply_word(c2, 3, 8'h02, 40'h0), 4);
    n_run++;
    if (done_cnt - d0 !== 1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL busy_orig_done: got pulses=%0d state=%0d, required 1 and 0", done_cnt - d0, dbg_state);
    end
  endtask

  task automatic test_reset_mid_payload();
    int d0;
    issue_cmd(c1);
    send_payload(5, 64'h50, 64'd1, 1'b0);
    pay_data  = 64'h55;
    pay_keep  = 8'hFF;
    pay_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_run++;
    if ({stream_out_valid, pay_ready, cmd_ready, stream_in_ready, busy, done, dbg_state} !== 8'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got sov=%b pr=%b cr=%b sir=%b busy=%b done=%b st=%0d, required all 0",
               stream_out_valid, pay_ready, cmd_ready, stream_in_ready, busy, done, dbg_state);
    end
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_sent: got %0d beats unsent, required 0", exp_q.size());
      exp_q.delete();
    end
    pay_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if (cmd_ready !== 1'b1 || stream_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release: got cr=%b sir=%b, required 1 1", cmd_ready, stream_in_ready);
    end
    issue_cmd(c2);
    send_payload(2, 64'h900, 64'd1, 1'b1);
    wait_drain();
    d0 = done_cnt;
    send_rx(reply_word(c2, 0, 8'h02, 40'h0), reply_word(c2, 1, 8'h02, 40'h0),
            reply_word(c2, 2, 8'h02, 40'h0), reply_word(c2, 3, 8'h02, 40'h0), 4);
    n_run++;
    if (done_cnt - d0 !== 1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_then_done: got pulses=%0d state=%0d, required 1 and 0", done_cnt - d0, dbg_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    c1 = '{dst: 16'd1, src: 8'd0, size: 32'd2, macd: 48'hfa163e55ca02,
           macs: 48'h0cc47a88c047, ipd: 32'd0, ips: 32'd0};
    c2 = '{dst: 16'h0103, src: 8'd5, size: 32'd88, macd: 48'h112233445566,
           macs: 48'ha1b2c3d4e5f6, ipd: 32'h0a000001, ips: 32'h0a000002};
    c3 = '{dst: 16'd9, src: 8'd7, size: 32'd1, macd: 48'h0000deadbeef,
           macs: 48'h00000badcafe, ipd: 32'hc0a80001, ips: 32'hc0a80002};
    test_reset();
    test_idle_rx();
    test_basic_send();
    test_done_match();
    test_backpressure();
    test_wrong_done();
    test_cmd_while_busy();
    test_reset_mid_payload();
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d beats pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mpi_eth_interface.md
MPI_ETH_INTERFACE -- requirements
Module: mpi_eth_interface

Interface
REQ-001 SHALL have parameter ETHERTYPE, default 16'h88B5, EtherType written to and matched in the header.
REQ-002 SHALL have parameter OP_SEND, default 8'h01, send opcode.
REQ-003 SHALL have parameter OP_DONE, default 8'h02, done opcode.
REQ-004 SHALL use one clock; reset is asynchronous and active-high. The ports are:
- clk  in  1  clock
- rst  in  1  reset, asynchronous active-high
- cmd_valid/cmd_ready  in/out  1/1  send-command handshake
- cmd_dst_rank  in  16  destination rank
- cmd_src_rank  in  8  source rank
- cmd_size  in  32  message size, carried only
- cmd_mac_dst/cmd_mac_src  in  48/48  MAC addresses
- cmd_ip_dst/cmd_ip_src  in  32/32  IP addresses
- pay_data/pay_keep/pay_last/pay_valid  in  64/8/1/1  payload AXI-Stream
- pay_ready  out  1  payload ready
- stream_out_data/keep/last/valid  out  64/8/1/1  network transmit AXI-Stream
- stream_out_ready  in  1  transmit ready
- stream_in_data/keep/last/valid  in  64/8/1/1  network receive AXI-Stream
- stream_in_ready  out  1  receive ready
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle pulse when the matching DONE packet is received

Function
REQ-005 SHALL implement states IDLE, HDR, PAYLOAD and WAIT_DONE.
REQ-006 IDLE behaviour: SHALL drive cmd_ready=1. On cmd_valid, SHALL register all cmd_* fields, set header index=0, and go to HDR. The first header beat SHALL be valid on the next cycle.
REQ-007 cmd_ready SHALL be 0 outside IDLE, so commands are not accepted while busy.
REQ-008 HDR SHALL emit 4 beats, each with keep=8'hFF and last=0. Byte 0 of each beat is bits 63:56.
- H0 = {mac_dst[47:0], mac_src[47:32]}
- H1 = {mac_src[31:0], ETHERTYPE, OP_SEND, 8'h00}
- H2 = {ip_dst, ip_src}
- H3 = {dst_rank, src_rank, 8'h00, size}
REQ-009 In HDR, the header index SHALL advance only on stream_out_valid & stream_out_ready. The beat is held stable while ready=0. The transfer of H3 SHALL move the state to PAYLOAD.
REQ-010 PAYLOAD SHALL pass beats through combinationally:
- stream_out_data/keep/last/valid = pay_data/keep/last/valid
- pay_ready = stream_out_ready
REQ-011 Outside PAYLOAD, pay_ready SHALL be 0.
REQ-012 A transferred payload beat with pay_last=1 SHALL end PAYLOAD and move the state to WAIT_DONE. The beat count SHALL NOT be checked against size.
REQ-013 stream_out_valid SHALL be 0 in IDLE and WAIT_DONE.
REQ-014 stream_in_ready SHALL be 1 in every state when not in reset. Received packets SHALL be consumed and discarded unless they match per REQ-015.
REQ-015 In WAIT_DONE, a received packet SHALL match only if all of the following hold:
- exactly 4 beats, last on beat 3 only
- B0 = {mac_src, mac_dst[47:32]} of the stored command
- B1 = {mac_dst[31:0], ETHERTYPE, OP_DONE, 8'h00}
- B2 = {ip_src, ip_dst}
- B3[63:40] = {cmd_src_rank zero-extended to 16 bits, cmd_dst_rank[7:0]}
REQ-016 B3[39:0] SHALL be ignored during matching.
REQ-017 A received packet SHALL be tracked with a receive beat counter and a mismatch flag. Both SHALL reset on each beat with last=1.
REQ-018 On the last beat of a matching packet, the block SHALL pulse done=1 for exactly one cycle and return to IDLE on the next cycle.
REQ-019 Packets received outside WAIT_DONE, or that fail to match, SHALL be discarded with no state change.
REQ-020 A packet already in progress when WAIT_DONE is entered SHALL be ignored; matching starts at the next first beat.
REQ-021 A non-matching packet longer than 4 beats SHALL be discarded up to and including its last beat.
REQ-022 busy SHALL be 1 in HDR, PAYLOAD and WAIT_DONE.

Reset
REQ-023 rst=1 SHALL immediately force the following, regardless of the current state, including mid-header, mid-payload and mid-receive:
- state=IDLE
- header index=0, receive counter=0, mismatch flag=0
- done=0
- stream_out_valid=0, stream_in_ready=0, pay_ready=0, cmd_ready=0
REQ-024 Stored command registers SHALL reset to 0.
REQ-025 After rst deasserts, the block SHALL accept a new command normally.

Structure
REQ-026 A shared package mpi_eth_pkg SHALL hold the state enum, ETHERTYPE, OP_SEND, OP_DONE and the header beat count (4).
REQ-027 One sub-module, mpi_done_matcher, SHALL implement the receive matching of REQ-015 to REQ-021 and output a match pulse. Everything else is in the top level.

Verification
REQ-028 Basic send: cmd dst_rank=1, src_rank=0, size=2, mac_dst=48'hfa163e55ca02, mac_src=48'h0cc47a88c047, IPs=0, with 11 payload beats of 64'd13 (last on the 11th). Required stream_out:
- H0=64'hfa163e55ca020cc4
- H1=64'h7a88c04788b50100
- H2=0
- H3=64'h0001000000000002
- then 11 beats of data 13 with keep FF, last only on the 11th; busy=1
REQ-029 Done match: after REQ-028, inject B0=64'h0cc47a88c047fa16, B1=64'h3e55ca0288b50200, B2=0, B3=64'h0000010000000000 -> done pulses once, then IDLE and busy=0.
REQ-030 Backpressure: toggle stream_out_ready randomly during REQ-028 -> beat order and content are unchanged and no beat is duplicated.
REQ-031 Wrong DONE: reply with src_rank field 2, or with opcode 01 -> no done, state remains WAIT_DONE; a correct packet afterwards -> done.
REQ-032 Reset mid-payload: assert rst after payload beat 5 -> outputs are zero immediately; after release, a new command produces a fresh H0.
REQ-033 Command while busy: assert cmd_valid during PAYLOAD -> cmd_ready=0 and the stored fields are unchanged.
